// File: rtl/mem_io_responder_if.sv
// CPU byte memory bus between the cpu (master) and mem_io_responder (slave).
// Address, direction and write data flow to the responder; read data and ready flow back.
interface mem_io_responder_if;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic [7:0]  mem_dout;
  logic [7:0]  mem_din;
  logic        rdy_out;

  modport master (output mem_a, mem_wr, mem_dout, input  mem_din, rdy_out);
  modport slave  (input  mem_a, mem_wr, mem_dout, output mem_din, rdy_out);
endinterface

// File: rtl/mem_io_responder.sv
// Responder for the cpu byte bus: byte RAM plus the I/O page at 0x30000 (UART FIFOs, cycle counter, stop).
module mem_io_responder #(
  parameter int    ADDR_W    = 17,
  parameter int    TX_DEPTH  = 16,
  parameter int    RX_DEPTH  = 8,
  parameter string INIT_FILE = "test.data"
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  mem_io_responder_if.slave    bus,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  output logic                 rx_ready,
  output logic                 sim_stop,
  output logic                 tx_ovf
);

  localparam int TX_AW = $clog2(TX_DEPTH);
  localparam int TX_CW = $clog2(TX_DEPTH + 1);
  localparam int RX_AW = $clog2(RX_DEPTH);
  localparam int RX_CW = $clog2(RX_DEPTH + 1);

  logic [7:0] ram    [2**ADDR_W];
  logic [7:0] tx_mem [TX_DEPTH];
  logic [7:0] rx_mem [RX_DEPTH];

  logic [7:0]       mem_din_q, mem_din_d;
  logic             rdy_q, rdy_d;
  logic             sim_stop_q, sim_stop_d;
  logic             tx_ovf_q, tx_ovf_d;
  logic [31:0]      cnt_q, cnt_d;
  logic [31:0]      snap_q, snap_d;
  logic [TX_AW-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
  logic [TX_CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [RX_AW-1:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
  logic [RX_CW-1:0] rx_cnt_q, rx_cnt_d;

  logic              io_hit, hole_hit, ram_hit, rd, wr;
  logic [2:0]        io_off;
  logic [ADDR_W-1:0] ram_idx;
  logic              ram_we;
  logic              tx_push_req, tx_push, tx_pop, tx_full;
  logic [7:0]        tx_push_byte;
  logic              rx_push, rx_pop, rx_full;
  logic              unused_addr_bits;

  assign unused_addr_bits = &{1'b0, bus.mem_a[31:18]};

  assign io_hit   = (bus.mem_a[17:16] == 2'b11);
  assign hole_hit = (bus.mem_a[17:16] == 2'b10);
  assign ram_hit  = ~bus.mem_a[17];
  assign io_off   = bus.mem_a[2:0];
  assign ram_idx  = bus.mem_a[ADDR_W-1:0];
  assign wr       = bus.mem_wr;
  assign rd       = ~bus.mem_wr;
  assign ram_we   = wr & ram_hit;

  assign tx_valid = (tx_cnt_q != '0);
  assign tx_full  = (tx_cnt_q == TX_CW'(TX_DEPTH));
  assign tx_data  = tx_mem[tx_rp_q];
  assign tx_pop   = tx_valid & tx_ready;
  assign tx_push_req  = wr & io_hit & (((io_off == 3'd0) && (bus.mem_dout != 8'h00)) || (io_off == 3'd4));
  assign tx_push_byte = (io_off == 3'd4) ? 8'h00 : bus.mem_dout;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign tx_push  = tx_push_req & (~tx_full | tx_pop);

  // The cpu pop never makes room for a same-cycle uart push: rx_ready is judged on the current count.
  assign rx_full  = (rx_cnt_q == RX_CW'(RX_DEPTH));
  assign rx_ready = ~rx_full;
  assign rx_push  = rx_valid & ~rx_full;
  assign rx_pop   = rd & io_hit & (io_off == 3'd0) & (rx_cnt_q != '0);

  assign bus.mem_din = mem_din_q;
  assign bus.rdy_out = rdy_q;
  assign sim_stop    = sim_stop_q;
  assign tx_ovf      = tx_ovf_q;

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can leave a latch behind.
    mem_din_d  = mem_din_q;
    snap_d     = snap_q;
    sim_stop_d = sim_stop_q | (wr & io_hit & (io_off == 3'd4));
    tx_ovf_d   = tx_ovf_q | (tx_push_req & tx_full & ~tx_pop);
    cnt_d      = sim_stop_q ? cnt_q : cnt_q + 32'd1;

    if (rd) begin
      if (io_hit) begin
        unique case (io_off)
          3'd0:    mem_din_d = rx_pop ? rx_mem[rx_rp_q] : 8'h00;
          3'd4:    begin
                     mem_din_d = cnt_q[7:0];
                     snap_d    = cnt_q;
                   end
          3'd5:    mem_din_d = snap_q[15:8];
          3'd6:    mem_din_d = snap_q[23:16];
          3'd7:    mem_din_d = snap_q[31:24];
          default: mem_din_d = 8'h00;
        endcase
      end else if (hole_hit) begin
        mem_din_d = 8'h00;
      end else begin
        mem_din_d = ram[ram_idx];
      end
    end

    tx_wp_d  = tx_push ? tx_wp_q + TX_AW'(1) : tx_wp_q;
    tx_rp_d  = tx_pop  ? tx_rp_q + TX_AW'(1) : tx_rp_q;
    tx_cnt_d = tx_cnt_q;
    if (tx_push && !tx_pop)      tx_cnt_d = tx_cnt_q + TX_CW'(1);
    else if (!tx_push && tx_pop) tx_cnt_d = tx_cnt_q - TX_CW'(1);
    // One spare slot stays free for the write the cpu already issued when ready drops.
    rdy_d = (tx_cnt_d < TX_CW'(TX_DEPTH - 1));

    rx_wp_d  = rx_push ? rx_wp_q + RX_AW'(1) : rx_wp_q;
    rx_rp_d  = rx_pop  ? rx_rp_q + RX_AW'(1) : rx_rp_q;
    rx_cnt_d = rx_cnt_q;
    if (rx_push && !rx_pop)      rx_cnt_d = rx_cnt_q + RX_CW'(1);
    else if (!rx_push && rx_pop) rx_cnt_d = rx_cnt_q - RX_CW'(1);
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      mem_din_q  <= 8'h00;
      rdy_q      <= 1'b1;
      sim_stop_q <= 1'b0;
      tx_ovf_q   <= 1'b0;
      cnt_q      <= '0;
      snap_q     <= '0;
      tx_wp_q    <= '0;
      tx_rp_q    <= '0;
      tx_cnt_q   <= '0;
      rx_wp_q    <= '0;
      rx_rp_q    <= '0;
      rx_cnt_q   <= '0;
    end else begin
      mem_din_q  <= mem_din_d;
      rdy_q      <= rdy_d;
      sim_stop_q <= sim_stop_d;
      tx_ovf_q   <= tx_ovf_d;
      cnt_q      <= cnt_d;
      snap_q     <= snap_d;
      tx_wp_q    <= tx_wp_d;
      tx_rp_q    <= tx_rp_d;
      tx_cnt_q   <= tx_cnt_d;
      rx_wp_q    <= rx_wp_d;
      rx_rp_q    <= rx_rp_d;
      rx_cnt_q   <= rx_cnt_d;
    end
  end

  // NOTE: storage arrays have no reset; emptiness is tracked by the reset pointers and counts.
  always_ff @(posedge clk_in) begin
    if (ram_we)  ram[ram_idx]     <= bus.mem_dout;
    if (tx_push) tx_mem[tx_wp_q]  <= tx_push_byte;
    if (rx_push) rx_mem[rx_wp_q]  <= rx_data;
  end

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed self-checking bench for mem_io_responder: RAM loop, UART tx/rx, back-pressure,
// cycle counter snapshot, stop register and asynchronous reset.
module tb_mem_io_responder;

  localparam logic [31:0] IDLE_A = 32'h0002_0000;  // write to the hole: no side effects

  logic       clk_in = 1'b0;
  logic       rst_in = 1'b1;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b0;
  logic [7:0] rx_data  = 8'h00;
  logic       rx_valid = 1'b0;
  logic       rx_ready;
  logic       sim_stop;
  logic       tx_ovf;

  int n_checks = 0;
  int n_errors = 0;
  int edges    = 0;
  logic [31:0] stop_val;

  mem_io_responder_if bus_if ();

  mem_io_responder dut (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .bus      (bus_if.slave),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .sim_stop (sim_stop),
    .tx_ovf   (tx_ovf)
  );

  always #5 clk_in = ~clk_in;

  // Edges since reset release; the DUT counter equals this until it is stopped.
  always @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) edges <= 0;
    else         edges <= edges + 1;
  end

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic bus_op(input logic wr, input logic [31:0] a, input logic [7:0] d);
    bus_if.mem_wr   = wr;
    bus_if.mem_a    = a;
    bus_if.mem_dout = d;
    tick();
    bus_if.mem_wr   = 1'b1;
    bus_if.mem_a    = IDLE_A;
    bus_if.mem_dout = 8'h00;
  endtask

  task automatic pop_tx();
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_mem_din"},  bus_if.mem_din,    8'h00);
    check({tag, "_rdy"},      8'(bus_if.rdy_out), 8'd1);
    check({tag, "_sim_stop"}, 8'(sim_stop),      8'd0);
    check({tag, "_tx_ovf"},   8'(tx_ovf),        8'd0);
    check({tag, "_tx_valid"}, 8'(tx_valid),      8'd0);
    check({tag, "_rx_ready"}, 8'(rx_ready),      8'd1);
  endtask

  initial begin
    bus_if.mem_wr   = 1'b1;
    bus_if.mem_a    = IDLE_A;
    bus_if.mem_dout = 8'h00;

    #2 rst_in = 1'b0;
    #1 check_reset_state("por");
    repeat (2) tick();
    rst_in = 1'b1;

    // Counter snapshot: read sampled while the counter holds 100.
    repeat (100) tick();
    bus_op(1'b0, 32'h0003_0004, 8'h00);
    check("cnt_at_100", bus_if.mem_din, 8'h64);
    bus_op(1'b0, 32'h0003_0005, 8'h00);
    check("snap_15_8", bus_if.mem_din, 8'h00);
    bus_op(1'b0, 32'h0003_0006, 8'h00);
    check("snap_23_16", bus_if.mem_din, 8'h00);
    bus_op(1'b0, 32'h0003_0007, 8'h00);
    check("snap_31_24", bus_if.mem_din, 8'h00);
    bus_op(1'b0, 32'h0003_0004, 8'h00);
    check("cnt_running", bus_if.mem_din, 8'h68);
    bus_op(1'b0, 32'h0003_0002, 8'h00);
    check("io_other_rd", bus_if.mem_din, 8'h00);

    // RAM loop and decode.
    bus_op(1'b0, 32'h0003_0004, 8'h00);
    bus_op(1'b1, 32'h0000_0123, 8'hA5);
    check("wr_keeps_din", bus_if.mem_din, 8'h6A);
    bus_if.mem_wr = 1'b0;
    bus_if.mem_a  = 32'h0000_0123;
    #3 check("ram_rd_before_edge", bus_if.mem_din, 8'h6A);
    tick();
    check("ram_rd_A5", bus_if.mem_din, 8'hA5);
    bus_if.mem_wr = 1'b1;
    bus_if.mem_a  = IDLE_A;
    bus_op(1'b1, 32'h0001_0123, 8'h5A);
    bus_op(1'b1, 32'h0002_0123, 8'h77);
    bus_op(1'b0, 32'h0002_0123, 8'h00);
    check("hole_rd", bus_if.mem_din, 8'h00);
    bus_op(1'b0, 32'h0001_0123, 8'h00);
    check("ram_hi_rd", bus_if.mem_din, 8'h5A);
    bus_op(1'b0, 32'h0000_0123, 8'h00);
    check("ram_lo_kept", bus_if.mem_din, 8'hA5);

    // UART out: zero byte ignored.
    bus_op(1'b1, 32'h0003_0000, 8'h41);
    bus_op(1'b1, 32'h0003_0000, 8'h00);
    bus_op(1'b1, 32'h0003_0000, 8'h42);
    check("tx_valid", 8'(tx_valid), 8'd1);
    check("tx_head0", tx_data, 8'h41);
    pop_tx();
    check("tx_head1", tx_data, 8'h42);
    pop_tx();
    check("tx_empty", 8'(tx_valid), 8'd0);
    check("tx_ovf_clear", 8'(tx_ovf), 8'd0);

    // Back-pressure and overflow.
    for (int i = 1; i <= 14; i++) bus_op(1'b1, 32'h0003_0000, 8'(i));
    check("rdy_at_14", 8'(bus_if.rdy_out), 8'd1);
    bus_op(1'b1, 32'h0003_0000, 8'h0F);
    check("rdy_at_15", 8'(bus_if.rdy_out), 8'd0);
    bus_op(1'b1, 32'h0003_0000, 8'h10);
    check("ovf_at_16", 8'(tx_ovf), 8'd0);
    bus_op(1'b1, 32'h0003_0000, 8'h11);
    check("ovf_drop", 8'(tx_ovf), 8'd1);
    check("bp_head", tx_data, 8'h01);
    pop_tx();
    check("rdy_pop1", 8'(bus_if.rdy_out), 8'd0);
    check("bp_head1", tx_data, 8'h02);
    pop_tx();
    check("rdy_pop2", 8'(bus_if.rdy_out), 8'd1);
    check("bp_head2", tx_data, 8'h03);
    repeat (13) pop_tx();
    check("bp_last", tx_data, 8'h10);
    pop_tx();
    check("bp_drained", 8'(tx_valid), 8'd0);
    check("ovf_sticky", 8'(tx_ovf), 8'd1);

    // UART in.
    rx_data = 8'h37; rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    bus_op(1'b0, 32'h0003_0000, 8'h00);
    check("rx_37", bus_if.mem_din, 8'h37);
    bus_op(1'b0, 32'h0003_0000, 8'h00);
    check("rx_empty_rd", bus_if.mem_din, 8'h00);
    rx_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rx_data = 8'h50 + 8'(i);
      tick();
      if (i == 6) check("rx_ready_at_7", 8'(rx_ready), 8'd1);
    end
    check("rx_full", 8'(rx_ready), 8'd0);
    rx_data = 8'hEE;
    bus_op(1'b0, 32'h0003_0000, 8'h00);
    rx_valid = 1'b0;
    check("rx_head_full_pop", bus_if.mem_din, 8'h50);
    check("rx_ready_after_pop", 8'(rx_ready), 8'd1);
    for (int i = 1; i < 8; i++) begin
      bus_op(1'b0, 32'h0003_0000, 8'h00);
      check("rx_drain", bus_if.mem_din, 8'h50 + 8'(i));
    end
    bus_op(1'b0, 32'h0003_0000, 8'h00);
    check("rx_no_ee", bus_if.mem_din, 8'h00);

    // Stop register.
    bus_op(1'b1, 32'h0003_0004, 8'hFF);
    stop_val = 32'(edges);
    check("sim_stop", 8'(sim_stop), 8'd1);
    check("stop_tx_valid", 8'(tx_valid), 8'd1);
    check("stop_tx_zero", tx_data, 8'h00);
    repeat (5) tick();
    bus_op(1'b0, 32'h0003_0004, 8'h00);
    check("cnt_frozen", bus_if.mem_din, stop_val[7:0]);
    bus_op(1'b0, 32'h0003_0005, 8'h00);
    check("cnt_frozen_hi", bus_if.mem_din, stop_val[15:8]);
    pop_tx();
    check("stop_tx_drained", 8'(tx_valid), 8'd0);
    bus_op(1'b0, 32'h0000_0123, 8'h00);
    check("ram_after_stop", bus_if.mem_din, 8'hA5);

    // Asynchronous reset in the middle of a read.
    bus_op(1'b1, 32'h0003_0000, 8'h55);
    rx_data = 8'h66; rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    check("pre_rst_tx", 8'(tx_valid), 8'd1);
    bus_if.mem_wr = 1'b0;
    bus_if.mem_a  = 32'h0003_0000;
    #3 rst_in = 1'b0;
    #1 check_reset_state("async");
    bus_if.mem_wr = 1'b1;
    bus_if.mem_a  = IDLE_A;
    tick();
    check("rst_held_din", bus_if.mem_din, 8'h00);
    rst_in = 1'b1;
    bus_op(1'b0, 32'h0003_0000, 8'h00);
    check("rx_flushed", bus_if.mem_din, 8'h00);
    check("tx_flushed", 8'(tx_valid), 8'd0);
    bus_op(1'b0, 32'h0000_0123, 8'h00);
    check("ram_survives_rst", bus_if.mem_din, 8'hA5);
    repeat (3) tick();
    bus_op(1'b0, 32'h0003_0004, 8'h00);
    check("cnt_restart", bus_if.mem_din, 8'(edges - 1));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
